fft_frame_ctrl: RTL and testbench

//   Frame sequencer for the FFT -> data_modulus magnitude path. Packs the ADC sample strobe

---
 rtl/fft_frame_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// fft_frame_ctrl
//
// Frame sequencer in front of the FFT -> magnitude path. It packs the ADC sample
// strobe into FFT_LEN-sample Avalon-ST frames for the FFT sink. It then holds off
// the next frame until the magnitude stream reports its end-of-packet, so only
// one frame is ever in flight. It reports frame completion, magnitude timeout and
// input overrun.
//
// Parameters
//   FFT_LEN  samples per frame (>= 2)
//   DATA_W   ADC / FFT sink sample width, two's complement
//   GAP_CYC  idle clocks between magnitude eop and the next frame (>= 1)
//   TIMEOUT  max clocks spent waiting for magnitude eop before abort (>= 1)
//
// Ports
//   clk_50m      in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   one-shot frame request, looked at in IDLE only
//   cont_en      in   re-arm automatically after the gap
//   adc_data     in   ADC sample
//   adc_valid    in   ADC sample strobe, one clock per sample
//   sink_ready   in   FFT sink ready
//   sink_valid   out  FFT sink valid
//   sink_sop     out  first sample of frame
//   sink_eop     out  last sample of frame
//   sink_real    out  held ADC sample
//   sink_imag    out  constant zero
//   mag_valid    in   data_valid from magnitude stage
//   mag_eop      in   data_eop from magnitude stage
//   busy         out  sequencer not idle
//   frame_done   out  one-clock pulse per completed frame
//   frame_cnt    out  completed frames, wraps 0xFFFF -> 0
//   timeout_err  out  sticky magnitude timeout flag
//   overrun_err  out  sticky dropped-sample flag
//   dbg_state    out  current FSM state (IDLE=0, FEED=1, WAIT_MAG=2, GAP=3)
//
// Sink handshake: a beat transfers on every rising edge where sink_valid and
// sink_ready are both 1. Once sink_valid is raised, sink_valid, sink_real,
// sink_imag, sink_sop and sink_eop hold steady until that transfer happens;
// sink_ready may change freely and never feeds back into sink_valid.
// -----------------------------------------------------------------------------
module fft_frame_ctrl #(
  parameter int FFT_LEN = 1024,
  parameter int DATA_W  = 16,
  parameter int GAP_CYC = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              start,
  input  logic              cont_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  input  logic              mag_valid,
  input  logic              mag_eop,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              timeout_err,
  output logic              overrun_err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FFT_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FEED     = 2'd1,
    ST_WAIT_MAG = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  state_t              state_q,       state_d;
  logic [CNT_W-1:0]    cnt_q,         cnt_d;
  logic                hold_full_q,   hold_full_d;
  logic [DATA_W-1:0]   hold_data_q,   hold_data_d;
  logic [TMR_W-1:0]    tmr_q,         tmr_d;
  logic [GAP_W-1:0]    gap_q,         gap_d;
  logic                frame_done_q,  frame_done_d;
  logic [15:0]         frame_cnt_q,   frame_cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic                overrun_err_q, overrun_err_d;

  logic beat_acc;
  logic last_beat;

  // The hold register only ever fills while in FEED and is emptied on the eop
  // beat, so hold_full_q alone is the sink valid.
  assign beat_acc  = hold_full_q & sink_ready;
  assign last_beat = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_full_d   = hold_full_q;
    hold_data_d   = hold_data_q;
    tmr_d         = tmr_q;
    gap_d         = gap_q;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    timeout_err_d = timeout_err_q;
    overrun_err_d = overrun_err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d       = '0;
        hold_full_d = 1'b0;
        if (start || cont_en) begin
          state_d = ST_FEED;
        end
      end

      ST_FEED: begin
        if (beat_acc) begin
          if (last_beat) begin
            // Frame complete: anything arriving alongside the eop beat
            // belongs to no frame and is discarded without an overrun.
            cnt_d       = '0;
            hold_full_d = 1'b0;
            tmr_d       = '0;
            state_d     = ST_WAIT_MAG;
          end else begin
            // Slot frees this edge, so a coincident sample refills it.
            cnt_d       = cnt_q + 1'b1;
            hold_full_d = adc_valid;
            if (adc_valid) begin
              hold_data_d = adc_data;
            end
          end
        end else if (adc_valid) begin
          if (hold_full_q) begin
            // Stalled with a sample still pending: drop the newcomer so the
            // presented beat stays stable.
            overrun_err_d = 1'b1;
          end else begin
            hold_full_d = 1'b1;
            hold_data_d = adc_data;
          end
        end
      end

      ST_WAIT_MAG: begin
        if (mag_valid && mag_eop) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          gap_d        = '0;
          state_d      = ST_GAP;
        end else if (tmr_q == TMR_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          cnt_d       = '0;
          hold_full_d = 1'b0;
          state_d     = cont_en ? ST_FEED : ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hold_full_q   <= 1'b0;
      hold_data_q   <= '0;
      tmr_q         <= '0;
      gap_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_full_q   <= hold_full_d;
      hold_data_q   <= hold_data_d;
      tmr_q         <= tmr_d;
      gap_q         <= gap_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sink_valid  = hold_full_q;
  assign sink_sop    = hold_full_q & (cnt_q == '0);
  assign sink_eop    = hold_full_q & last_beat;
  assign sink_real   = hold_data_q;
  assign sink_imag   = '0;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_ctrl
//
// Drives fft_frame_ctrl with FFT_LEN=8, GAP_CYC=6, TIMEOUT=64. A transaction
// model (one-slot occupancy + beat count per frame) predicts which ADC samples
// reach the sink and whether an overrun happens; a sink monitor pops the
// expected queue and checks data, sop/eop placement and stall stability.
// -----------------------------------------------------------------------------
module tb_fft_frame_ctrl;

  localparam int LEN = 8;
  localparam int DW  = 16;
  localparam int G   = 6;
  localparam int TO  = 64;

  // ---------------------------------------------------------------- clock/reset
  logic clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  logic          rst;
  logic          start;
  logic          cont_en;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic          sink_ready;
  logic          sink_valid;
  logic          sink_sop;
  logic          sink_eop;
  logic [DW-1:0] sink_real;
  logic [DW-1:0] sink_imag;
  logic          mag_valid;
  logic          mag_eop;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          timeout_err;
  logic          overrun_err;
  logic [1:0]    dbg_state;

  fft_frame_ctrl #(
    .FFT_LEN (LEN),
    .DATA_W  (DW),
    .GAP_CYC (G),
    .TIMEOUT (TO)
  ) dut (
    .clk_50m     (clk_50m),
    .rst         (rst),
    .start       (start),
    .cont_en     (cont_en),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .sink_ready  (sink_ready),
    .sink_valid  (sink_valid),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .sink_real   (sink_real),
    .sink_imag   (sink_imag),
    .mag_valid   (mag_valid),
    .mag_eop     (mag_eop),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q[$];
  bit            exp_ovr    = 1'b0;
  int            exp_frames = 0;
  int            obs_beats  = 0;

  // Sink monitor: runs forked from the main initial block.
  task automatic monitor_beats();
    int            mon_idx;
    bit            stall_prev;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] e;
    mon_idx    = 0;
    stall_prev = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk_50m);
      if (rst) begin
        mon_idx    = 0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && sink_valid) begin
          total++;
          if (sink_real !== prev_data) begin
            bad++;
            $display("FAIL stall_hold: got %0h want %0h", sink_real, prev_data);
          end
        end
        if (!sink_valid) begin
          total++;
          if ({sink_sop, sink_eop} !== 2'b00) begin
            bad++;
            $display("FAIL idle_sop_eop: got %b want 00", {sink_sop, sink_eop});
          end
        end
        if (sink_valid && sink_ready) begin
          obs_beats++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got data %0h want no beat", sink_real);
          end else begin
            e = exp_q.pop_front();
            if (sink_real !== e) begin
              bad++;
              $display("FAIL beat_data idx%0d: got %0h want %0h", mon_idx, sink_real, e);
            end
          end
          total++;
          if (sink_sop !== (mon_idx == 0)) begin
            bad++;
            $display("FAIL beat_sop idx%0d: got %b want %b", mon_idx, sink_sop, (mon_idx == 0));
          end
          total++;
          if (sink_eop !== (mon_idx == LEN - 1)) begin
            bad++;
            $display("FAIL beat_eop idx%0d: got %b want %b", mon_idx, sink_eop, (mon_idx == LEN - 1));
          end
          total++;
          if (sink_imag !== '0) begin
            bad++;
            $display("FAIL beat_imag: got %0h want 0", sink_imag);
          end
          mon_idx = (mon_idx == LEN - 1) ? 0 : mon_idx + 1;
        end
        stall_prev = sink_valid && !sink_ready;
        prev_data  = sink_real;
      end
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic start_frame();
    start = 1'b1;
    @(posedge clk_50m); #1;
    start = 1'b0;
  endtask

  // Feeds one frame starting in the first FEED cycle. The model tracks the
  // single hold slot and the number of delivered beats; it ends right after the
  // edge that accepts the eop beat (or after abort_beats beats if nonzero).
  task automatic feed_frame(input int period, input bit rnd_ready, input int stall_at,
                            input int stall_len, input int abort_beats, input bit rnd_start);
    int            cyc;
    int            beats_m;
    bit            occ;
    bit            done;
    bit            acc;
    bit            av;
    bit            rdy;
    logic [DW-1:0] d;
    cyc     = 0;
    beats_m = 0;
    occ     = 1'b0;
    done    = 1'b0;
    while (!done) begin
      if (cyc >= 1000) begin
        total++;
        bad++;
        $display("FAIL feed_budget: beats %0d want %0d", beats_m, LEN);
        break;
      end
      rdy = rnd_ready ? ($urandom_range(0, 3) != 0)
                      : !(cyc >= stall_at && cyc < stall_at + stall_len);
      av  = (period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % period) == 0);
      d   = DW'($urandom);
      sink_ready = rdy;
      adc_valid  = av;
      adc_data   = d;
      start      = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = occ && rdy;
      if (acc) beats_m++;
      if (acc && beats_m == LEN) begin
        occ  = 1'b0;
        done = 1'b1;
      end else if (av) begin
        if (occ && !acc) exp_ovr = 1'b1;
        else begin
          exp_q.push_back(d);
          occ = 1'b1;
        end
      end else if (acc) begin
        occ = 1'b0;
      end
      @(posedge clk_50m); #1;
      cyc++;
      if (abort_beats > 0 && beats_m == abort_beats) done = 1'b1;
    end
    adc_valid  = 1'b0;
    sink_ready = 1'b1;
    start      = 1'b0;
  endtask

  // Starts in the first WAIT_MAG cycle; returns in the cycle after the gap.
  task automatic finish_frame(input int delay, input bit rearm);
    bit mv;
    for (int i = 0; i < delay; i++) begin
      mv        = 1'($urandom_range(0, 1));
      mag_valid = mv;
      mag_eop   = !mv && 1'($urandom_range(0, 1));
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = DW'($urandom);
      @(posedge clk_50m); #1;
    end
    total++;
    if (frame_done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wait_mag_state: got done=%b busy=%b want done=0 busy=1", frame_done, busy);
    end
    mag_valid = 1'b1;
    mag_eop   = 1'b1;
    adc_valid = 1'b0;
    @(posedge clk_50m); #1;
    mag_valid = 1'b0;
    mag_eop   = 1'b0;
    exp_frames++;
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL frame_done_pulse: got %b want 1", frame_done);
    end
    total++;
    if (frame_cnt !== 16'(exp_frames)) begin
      bad++;
      $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, 16'(exp_frames));
    end
    for (int g = 0; g < G; g++) begin
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = DW'($urandom);
      mag_valid = 1'($urandom_range(0, 1));
      mag_eop   = 1'($urandom_range(0, 1));
      @(posedge clk_50m); #1;
      if (g == 0) begin
        total++;
        if (frame_done !== 1'b0) begin
          bad++;
          $display("FAIL frame_done_len: got %b want 0", frame_done);
        end
      end
      if (g < G - 1) begin
        total++;
        if (busy !== 1'b1 || sink_valid !== 1'b0) begin
          bad++;
          $display("FAIL gap_state g%0d: got busy=%b valid=%b want busy=1 valid=0", g, busy, sink_valid);
        end
      end
    end
    adc_valid = 1'b0;
    mag_valid = 1'b0;
    mag_eop   = 1'b0;
    total++;
    if (busy !== rearm) begin
      bad++;
      $display("FAIL gap_exit: got busy=%b want %b", busy, rearm);
    end
    total++;
    if (frame_cnt !== 16'(exp_frames) || overrun_err !== exp_ovr) begin
      bad++;
      $display("FAIL after_gap: got cnt=%0d ovr=%b want cnt=%0d ovr=%b",
               frame_cnt, overrun_err, 16'(exp_frames), exp_ovr);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1;
    total++;
    if ({sink_valid, sink_sop, sink_eop, busy, frame_done, timeout_err, overrun_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {sink_valid, sink_sop, sink_eop, busy, frame_done, timeout_err, overrun_err});
    end
    total++;
    if (sink_real !== '0 || sink_imag !== '0 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_data: got real=%0h imag=%0h cnt=%0d want 0 0 0", sink_real, sink_imag, frame_cnt);
    end
    rst = 1'b0;
    // Magnitude eop and ADC strobes in IDLE must be ignored.
    mag_valid = 1'b1;
    mag_eop   = 1'b1;
    adc_valid = 1'b1;
    @(posedge clk_50m); #1;
    mag_valid = 1'b0;
    mag_eop   = 1'b0;
    @(posedge clk_50m); #1;
    adc_valid = 1'b0;
    total++;
    if (frame_done !== 1'b0 || frame_cnt !== 16'd0 || busy !== 1'b0 ||
        sink_valid !== 1'b0 || overrun_err !== 1'b0) begin
      bad++;
      $display("FAIL idle_ignore: got done=%b cnt=%0d busy=%b valid=%b ovr=%b want all 0",
               frame_done, frame_cnt, busy, sink_valid, overrun_err);
    end
  endtask

  task automatic test_single_frame();
    obs_beats = 0;
    start_frame();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL feed_busy: got %b want 1", busy);
    end
    feed_frame(4, 1'b0, -1, 0, 0, 1'b0);
    total++;
    if (obs_beats !== LEN || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL single_beats: got %0d left %0d want %0d left 0", obs_beats, exp_q.size(), LEN);
    end
    total++;
    if (overrun_err !== exp_ovr) begin
      bad++;
      $display("FAIL single_ovr: got %b want %b", overrun_err, exp_ovr);
    end
    finish_frame(19, 1'b0);
  endtask

  task automatic test_overrun();
    obs_beats = 0;
    start_frame();
    feed_frame(2, 1'b0, 1, 6, 0, 1'b0);
    total++;
    if (obs_beats !== LEN || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL ovr_beats: got %0d left %0d want %0d left 0", obs_beats, exp_q.size(), LEN);
    end
    total++;
    if (overrun_err !== exp_ovr) begin
      bad++;
      $display("FAIL ovr_flag: got %b want %b", overrun_err, exp_ovr);
    end
    finish_frame($urandom_range(1, 30), 1'b0);
  endtask

  task automatic test_timeout();
    bit saw_done;
    saw_done  = 1'b0;
    obs_beats = 0;
    start_frame();
    feed_frame(3, 1'b0, -1, 0, 0, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      adc_valid = 1'($urandom_range(0, 1));
      mag_valid = 1'($urandom_range(0, 1));
      mag_eop   = 1'b0;
      @(posedge clk_50m); #1;
      if (frame_done) saw_done = 1'b1;
    end
    adc_valid = 1'b0;
    mag_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: got busy=%b err=%b want busy=1 err=0", busy, timeout_err);
    end
    @(posedge clk_50m); #1;
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_fire: got busy=%b err=%b want busy=0 err=1", busy, timeout_err);
    end
    total++;
    if (frame_cnt !== 16'(exp_frames) || saw_done || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL timeout_cnt: got cnt=%0d done_seen=%b want cnt=%0d done_seen=0",
               frame_cnt, saw_done, 16'(exp_frames));
    end
  endtask

  task automatic test_continuous();
    cont_en = 1'b1;
    @(posedge clk_50m); #1;
    for (int f = 0; f < 3; f++) begin
      obs_beats = 0;
      if (f == 2) cont_en = 1'b0;
      feed_frame(2, 1'b0, -1, 0, 0, 1'b0);
      total++;
      if (obs_beats !== LEN || exp_q.size() !== 0) begin
        bad++;
        $display("FAIL cont_beats f%0d: got %0d left %0d want %0d left 0", f, obs_beats, exp_q.size(), LEN);
      end
      finish_frame($urandom_range(1, 30), (f < 2));
    end
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 4; k++) begin
      obs_beats = 0;
      start_frame();
      feed_frame(0, 1'b1, -1, 0, 0, 1'b1);
      total++;
      if (obs_beats !== LEN || exp_q.size() !== 0) begin
        bad++;
        $display("FAIL rand_beats k%0d: got %0d left %0d want %0d left 0", k, obs_beats, exp_q.size(), LEN);
      end
      total++;
      if (overrun_err !== exp_ovr) begin
        bad++;
        $display("FAIL rand_ovr k%0d: got %b want %b", k, overrun_err, exp_ovr);
      end
      finish_frame($urandom_range(0, 40), 1'b0);
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_beats = 0;
    start_frame();
    feed_frame(2, 1'b0, -1, 0, 4, 1'b0);
    // Present a fifth sample but stall it so it is pending when reset hits.
    sink_ready = 1'b0;
    adc_valid  = 1'b1;
    adc_data   = DW'($urandom);
    @(posedge clk_50m); #1;
    adc_valid = 1'b0;
    total++;
    if (sink_valid !== 1'b1 || obs_beats !== 4) begin
      bad++;
      $display("FAIL pre_rst: got valid=%b beats=%0d want valid=1 beats=4", sink_valid, obs_beats);
    end
    rst = 1'b1;
    @(posedge clk_50m); #1;
    total++;
    if ({sink_valid, sink_sop, sink_eop, busy, frame_done, timeout_err, overrun_err} !== 7'b0) begin
      bad++;
      $display("FAIL mid_rst_flags: got %b want 0000000",
               {sink_valid, sink_sop, sink_eop, busy, frame_done, timeout_err, overrun_err});
    end
    total++;
    if (sink_real !== '0 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_rst_data: got real=%0h cnt=%0d want 0 0", sink_real, frame_cnt);
    end
    rst        = 1'b0;
    sink_ready = 1'b1;
    exp_q.delete();
    exp_ovr    = 1'b0;
    exp_frames = 0;
    obs_beats  = 0;
    start_frame();
    feed_frame(3, 1'b0, -1, 0, 0, 1'b0);
    total++;
    if (obs_beats !== LEN || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL post_rst_beats: got %0d left %0d want %0d left 0", obs_beats, exp_q.size(), LEN);
    end
    finish_frame(5, 1'b0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cont_en    = 1'b0;
    adc_data   = '0;
    adc_valid  = 1'b0;
    sink_ready = 1'b1;
    mag_valid  = 1'b0;
    mag_eop    = 1'b0;
    fork
      monitor_beats();
    join_none
    test_reset();
    test_single_frame();
    test_overrun();
    test_timeout();
    test_continuous();
    test_random_frames();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want completion within 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
